// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage (master) and the memory (slave).
// Handshake: the master holds imem_req=1 with a stable imem_addr until the slave
// answers with imem_ready=1 in a cycle; imem_rdata is the word at imem_addr only in
// that cycle. No word is transferred in a cycle where imem_ready=0.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the 5-stage MIPS pipe.
// Owns the PC, drives a variable-latency instruction memory, keeps a skid word when
// decode is stalled at the moment the memory answers, and remembers redirects that
// arrive while a fetch is still outstanding so that the stale word is dropped.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          pc_src,
   input  logic [31:0]   pc_target,
   if_stage_if.master    imem,
   output logic [31:0]   instruction,
   output logic [31:0]   pcPlus4,
   output logic          if_id_valid,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_skid;
   logic [31:0] r_redir;
   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   logic        w_take;
   logic [31:0] w_pc_plus4;

   // A redirect from decode only counts when the pipeline is moving.
   assign w_take     = pc_src & ~stall;
   assign w_pc_plus4 = r_pc + 32'd4;

   // HOLD already owns the fetched word, so no request is outstanding there.
   assign imem.imem_req  = (r_state != S_HOLD);
   assign imem.imem_addr = r_pc;

   assign instruction = r_instr;
   assign pcPlus4     = r_pc4;
   assign if_id_valid = r_valid;
   assign o_dbg_state = r_state;

   // Fetch FSM, PC, skid/redirect registers and IF/ID register in one process.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_skid  <= 32'd0;
         r_redir <= 32'd0;
         r_instr <= NOP_INSTR;
         r_pc4   <= 32'd0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem.imem_ready) begin
                  if (stall) begin
                     // Decode cannot take the word; park it and stop requesting.
                     r_skid  <= imem.imem_rdata;
                     r_state <= S_HOLD;
                  end else if (pc_src) begin
                     // Word belongs to the wrong path; drop it.
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                     r_pc    <= pc_target;
                  end else begin
                     r_instr <= imem.imem_rdata;
                     r_pc4   <= w_pc_plus4;
                     r_valid <= 1'b1;
                     r_pc    <= w_pc_plus4;
                  end
               end else begin
                  if (!stall) begin
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                  end
                  // Address must stay put until the memory answers, so remember the target.
                  if (w_take) begin
                     r_redir <= pc_target;
                     r_state <= S_DISCARD;
                  end
               end
            end

            S_HOLD: begin
               if (!stall) begin
                  if (pc_src) begin
                     r_instr <= NOP_INSTR;
                     r_valid <= 1'b0;
                     r_pc    <= pc_target;
                  end else begin
                     r_instr <= r_skid;
                     r_pc4   <= w_pc_plus4;
                     r_valid <= 1'b1;
                     r_pc    <= w_pc_plus4;
                  end
                  r_state <= S_FETCH;
               end
            end

            S_DISCARD: begin
               if (!stall) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end
               if (imem.imem_ready) begin
                  // A redirect arriving together with the stale word is the newer one.
                  r_pc    <= w_take ? pc_target : r_redir;
                  r_state <= S_FETCH;
               end else if (w_take) begin
                  r_redir <= pc_target;
               end
            end

            default: r_state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; directly upstream of the decode stage.
- Owns the PC and drives a variable-latency instruction-memory port.
- Delivers {instruction, pcPlus4, valid} to decode.
- Accepts stall from the hazard unit and branch/jump redirects resolved in decode (decode's branch adder plus equality compare).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) driven into IF/ID.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
stall  input  1  hazard unit: hold PC and IF/ID.
pc_src  input  1  decode: take redirect this cycle (branch taken or jump).
pc_target  input  32  decode: redirect target.
imem_req  output  1  fetch request; address valid.
imem_addr  output  32  fetch address (= PC).
imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
imem_rdata  input  32  fetched instruction.
instruction  output  32  IF/ID instruction to decode.
pcPlus4  output  32  IF/ID PC+4 to decode.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-wait): pc<=RESET_PC, state<=FETCH, instruction<=NOP_INSTR, pcPlus4<=0, if_id_valid<=0, skid and redirect registers cleared. An imem_ready arriving in the reset cycle is ignored.
- pc_src is qualified only when stall=0; with stall=1 it is ignored.
- "Deliver X": instruction<=X, pcPlus4<=pc+4, if_id_valid<=1.
- "Bubble": instruction<=NOP_INSTR, if_id_valid<=0, pcPlus4 unchanged.
- IF/ID register rules:
  - stall=1: IF/ID holds.
  - stall=0 and nothing delivered: bubble.
- imem_addr=pc at all times. pc changes only on the transitions listed below, so the address stays stable while a request is outstanding. pc+4 wraps modulo 2^32.
- State FETCH (imem_req=1):
  - ready=1, stall=0, pc_src=0: deliver imem_rdata; pc<=pc+4.
  - ready=1, stall=0, pc_src=1: bubble; pc<=pc_target; word dropped.
  - ready=1, stall=1: skid<=imem_rdata; ->HOLD; pc unchanged.
  - ready=0, stall=0, pc_src=1: redir<=pc_target; bubble; ->DISCARD.
  - ready=0 otherwise: wait; bubble if stall=0.
- State HOLD (imem_req=0):
  - stall=1: remain.
  - stall=0, pc_src=0: deliver skid; pc<=pc+4; ->FETCH.
  - stall=0, pc_src=1: bubble; pc<=pc_target; ->FETCH.
- State DISCARD (imem_req=1, address = old pc, held until ready):
  - ready=1: word dropped; pc<=redir; ->FETCH; bubble if stall=0.
  - Qualified pc_src in DISCARD overwrites redir; if it coincides with ready, the new pc_target wins.
- Latency: with imem_ready tied 1, the word at pc fetched in cycle N is visible at IF/ID after edge N, i.e. one instruction per cycle. A redirect costs exactly one bubble.
- Ordering: no instruction is ever duplicated or skipped. Every delivered instruction corresponds to a strictly sequential or redirected pc.

Test Plan:
- Zero-wait stream: ready=1, imem returns addr^32'hA5A5_0000, RESET_PC=0 → after reset, IF/ID shows A5A5_0000/pcPlus4 4, then A5A5_0004/8, then A5A5_0008/12, valid=1 each cycle.
- Two-cycle memory: ready every 2nd cycle → instructions alternate with bubbles (valid 0,1,0,1); imem_addr is stable across each wait; pc increments by 4 only on ready.
- Stall during delivery: at pc=0x10, ready=1 and stall=1 for 3 cycles → IF/ID is frozen, state HOLD, imem_req=0. On release, IF/ID gets word@0x10 with pcPlus4=0x14 and fetch resumes at 0x14.
- Redirect with ready: pc=0x20, ready=1, pc_src=1, pc_target=0x100 → IF/ID bubble; next imem_addr=0x100; the next delivered word is word@0x100 with pcPlus4=0x104.
- Redirect while waiting: pc=0x40, ready=0, pc_src=1 with target 0x200, then 2 cycles later ready=1 → word@0x40 never reaches IF/ID; imem_addr goes 0x40→0x200; IF/ID valid stays 0 until word@0x200.
- Reset mid-wait and in HOLD: rst=1 → pc=RESET_PC, valid=0, state FETCH; stale ready in the reset cycle is ignored; stall with pc_src=1 → pc unchanged.
